// File: rtl/reset_sequencer.sv
// Staged reset release sequencer: holds all domains in reset, then frees them in index order.
// Optional RESET_SEQ_SYNC_EN adds a two-flop synchronizer on RST_IN.
module reset_sequencer #(
  parameter int STAGES = 3,
  parameter int HOLD   = 64,
  parameter int GAP    = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              RST_IN,
  input  logic              SREQ,
  output logic              SACK,
  output logic [STAGES-1:0] RST_OUT,
  output logic              READY
);

  localparam int MAX_HG = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW     = $clog2(MAX_HG + 1);
  localparam int IW     = $clog2(STAGES + 1);

  localparam logic [CW-1:0]     HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0]     GAP_LAST  = CW'(GAP - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(STAGES);
  localparam logic [CW-1:0]     CNT_ZERO  = {CW{1'b0}};
  localparam logic [IW-1:0]     IDX_ZERO  = {IW{1'b0}};
  localparam logic [STAGES-1:0] ALL_ON    = {STAGES{1'b1}};

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [IW-1:0]     idx_r;
  logic [STAGES-1:0] rst_out_r;
  logic              ready_r;
  logic              sack_r;
  logic              pend_r;
  logic              rst_in_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      return v;
    end else begin
      return v + CW'(1'b1);
    end
  endfunction

`ifdef RESET_SEQ_SYNC_EN
  logic [1:0] sync_r;

  // Two-flop synchronizer; powers up in the asserted state
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], RST_IN};
    end
  end

  assign rst_in_s = sync_r[1];
`else
  assign rst_in_s = RST_IN;
`endif

  // Sequencer FSM: counter, stage index, staged outputs and soft-reset handshake
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r   <= ST_ASSERT;
      cnt_r     <= CNT_ZERO;
      idx_r     <= IDX_ZERO;
      rst_out_r <= ALL_ON;
      ready_r   <= 1'b0;
      sack_r    <= 1'b0;
      pend_r    <= 1'b0;
    end else begin
      // Acknowledge drops once the requester withdraws; a completing request below wins
      if (sack_r && !SREQ) begin
        sack_r <= 1'b0;
      end
      if (rst_in_s) begin
        state_r   <= ST_ASSERT;
        cnt_r     <= CNT_ZERO;
        idx_r     <= IDX_ZERO;
        rst_out_r <= ALL_ON;
        ready_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_ASSERT: begin
            if (cnt_r == HOLD_LAST) begin
              state_r   <= ST_RELEASE;
              cnt_r     <= CNT_ZERO;
              idx_r     <= IW'(1'b1);
              rst_out_r <= rst_out_r << 1'b1;
            end else begin
              cnt_r <= sat_inc(cnt_r);
            end
          end
          ST_RELEASE: begin
            if (cnt_r == GAP_LAST) begin
              cnt_r <= CNT_ZERO;
              if (idx_r == IDX_LAST) begin
                state_r <= ST_RUN;
                ready_r <= 1'b1;
                if (pend_r) begin
                  sack_r <= 1'b1;
                  pend_r <= 1'b0;
                end
              end else begin
                // Outputs clear strictly low-to-high, so a shift frees the next stage
                rst_out_r <= rst_out_r << 1'b1;
                idx_r     <= idx_r + IW'(1'b1);
              end
            end else begin
              cnt_r <= sat_inc(cnt_r);
            end
          end
          ST_RUN: begin
            if (SREQ && !sack_r) begin
              state_r   <= ST_ASSERT;
              cnt_r     <= CNT_ZERO;
              idx_r     <= IDX_ZERO;
              rst_out_r <= ALL_ON;
              ready_r   <= 1'b0;
              pend_r    <= 1'b1;
            end
          end
          default: begin
            state_r   <= ST_ASSERT;
            cnt_r     <= CNT_ZERO;
            idx_r     <= IDX_ZERO;
            rst_out_r <= ALL_ON;
            ready_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign RST_OUT = rst_out_r;
  assign READY   = ready_r;
  assign SACK    = sack_r;

endmodule
